// File: rtl/verify_result_checker.sv
// verify_result_checker
//   Compares AES core results against golden ciphertexts. Expected values are
//   queued in a small FIFO. Each accepted DUT result is checked against the
//   FIFO head over the full block width. Saturating counters record how many
//   results were compared and how many were correct.
//
//   Handshake: a transfer happens on a rising edge where both valid and ready
//   are 1. ready never depends combinationally on valid. It is decoded only
//   from the registered FSM state and the FIFO count.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   work                  level enable: 1 = run, 0 = stop accepting and drain
//   exp_valid/data/ready  golden ciphertext push into the FIFO
//   dut_valid/data/ready  AES result; an accept pops and compares the head
//   total, correct        saturating compare counters, cleared only by reset
//   mismatch              one-cycle pulse per failed compare
//   busy                  registered, high while not IDLE
//   fsm_state             current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//   fifo_count            current FIFO occupancy, 0..DEPTH
module verify_result_checker #(
   parameter int DATA_W = 128,
   parameter int CNT_W  = 32,
   parameter int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int FILL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              work,
   input  logic              exp_valid,
   input  logic [DATA_W-1:0] exp_data,
   output logic              exp_ready,
   input  logic              dut_valid,
   input  logic [DATA_W-1:0] dut_data,
   output logic              dut_ready,
   output logic [CNT_W-1:0]  total,
   output logic [CNT_W-1:0]  correct,
   output logic              mismatch,
   output logic              busy,
   output logic [1:0]        fsm_state,
   output logic [FILL_W-1:0] fifo_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FILL_W-1:0] count;
   logic              push;
   logic              pop;
   logic              equal;

   assign push       = exp_valid && exp_ready;
   assign pop        = dut_valid && dut_ready;
   assign equal      = (mem[rd_ptr] == dut_data);
   assign fifo_count = count;

   // State register. busy is computed from the next state so that the
   // registered flag always equals (state != IDLE).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (work) state_next = RUN;
         RUN:     if (!work) state_next = DRAIN;
         DRAIN: begin
            if (work)
               state_next = RUN;
            else if (count == '0)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode: registered state and count only
   always_comb begin
      fsm_state = state;
      exp_ready = (state == RUN) && (count != FULL_CNT);
      dut_ready = ((state == RUN) || (state == DRAIN)) && (count != '0);
   end

   // FIFO control. dut_ready needs a non-zero registered count, so a value
   // pushed on one edge can only be popped on a later edge (no bypass).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + FILL_W'(1);
            2'b01:   count <= count - FILL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage holds no control state, so it has no reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= exp_data;
   end

   // Compare result is registered at the accept edge, so it becomes visible
   // one cycle after the accept. correct only advances together with total,
   // which keeps total >= correct even at saturation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total    <= '0;
         correct  <= '0;
         mismatch <= 1'b0;
      end else begin
         mismatch <= 1'b0;
         if (pop) begin
            if (total != CNT_MAX) total <= total + CNT_W'(1);
            if (equal && (correct != CNT_MAX)) correct <= correct + CNT_W'(1);
            mismatch <= !equal;
         end
      end
   end

endmodule

// File: tb/tb_verify_result_checker.sv
`timescale 1ns/1ps
module tb_verify_result_checker;

   localparam int DATA_W = 128;
   localparam int CNT_W  = 4;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              work = 1'b0;
   logic              exp_valid = 1'b0;
   logic [DATA_W-1:0] exp_data = '0;
   logic              exp_ready;
   logic              dut_valid = 1'b0;
   logic [DATA_W-1:0] dut_data = '0;
   logic              dut_ready;
   logic [CNT_W-1:0]  total;
   logic [CNT_W-1:0]  correct;
   logic              mismatch;
   logic              busy;
   logic [1:0]        fsm_state;
   logic [2:0]        fifo_count;

   int checks = 0;
   int failures = 0;
   int mm_pulses = 0;
   logic [DATA_W-1:0] exp_q[$];

   verify_result_checker #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .work      (work),
      .exp_valid (exp_valid),
      .exp_data  (exp_data),
      .exp_ready (exp_ready),
      .dut_valid (dut_valid),
      .dut_data  (dut_data),
      .dut_ready (dut_ready),
      .total     (total),
      .correct   (correct),
      .mismatch  (mismatch),
      .busy      (busy),
      .fsm_state (fsm_state),
      .fifo_count(fifo_count)
   );

   // Clock: rising edges at 5, 15, 25 ... ns
   always #5 clk = ~clk;

   // Count cycles with mismatch high, sampled mid-cycle
   always @(negedge clk) begin
      if (mismatch === 1'b1) mm_pulses++;
   end

   // ---------------- driver tasks ----------------
   // All drivers start and end 1 ns after a rising edge.
   task automatic start_run();
      rst_n = 1'b0;
      work = 1'b0;
      exp_valid = 1'b0;
      dut_valid = 1'b0;
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mm_pulses = 0;
      work = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [DATA_W-1:0] d);
      int n = 0;
      exp_valid = 1'b1;
      exp_data = d;
      @(negedge clk);
      while (!exp_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!exp_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: exp_ready=%0b required 1", exp_ready);
      end else begin
         exp_q.push_back(d);
      end
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
   endtask

   task automatic accept_dut(input bit corrupt);
      logic [DATA_W-1:0] d;
      int n = 0;
      d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      if (corrupt) d[0] = ~d[0];
      dut_valid = 1'b1;
      dut_data = d;
      @(negedge clk);
      while (!dut_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!dut_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: dut_ready=%0b required 1", dut_ready);
      end
      @(posedge clk);
      #1;
      dut_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #500;
      checks++;
      if (total !== 4'd0 || correct !== 4'd0) begin
         failures++;
         $display("FAIL reset_counters: total=%0d correct=%0d required 0 0", total, correct);
      end
      checks++;
      if (mismatch !== 1'b0 || exp_ready !== 1'b0 || dut_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: mismatch=%0b exp_ready=%0b dut_ready=%0b busy=%0b required 0 0 0 0",
                  mismatch, exp_ready, dut_ready, busy);
      end
      checks++;
      if (fsm_state !== 2'd0 || fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_state: state=%0d count=%0d required 0 0", fsm_state, fifo_count);
      end
      #503;                 // rst_n rises at 1003 ns
      rst_n = 1'b1;
      #1997;                // 3000 ns: still IDLE with work low
      checks++;
      if (fsm_state !== 2'd0 || exp_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold: state=%0d exp_ready=%0b busy=%0b required 0 0 0",
                  fsm_state, exp_ready, busy);
      end
   endtask

   task automatic test_basic_match();
      #3006;                // work rises at 6006 ns
      work = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (fsm_state !== 2'd1 || exp_ready !== 1'b1 || dut_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL run_empty: state=%0d exp_ready=%0b dut_ready=%0b busy=%0b required 1 1 0 1",
                  fsm_state, exp_ready, dut_ready, busy);
      end
      @(posedge clk);
      #1;
      push_exp(128'h3ad77bb40d7a3660a89ecaf32466ef97);
      push_exp(128'hf5d3d58503b9699de785895a96fdbaaf);
      push_exp(128'h43b1cd7f598ece23881b00e3ed030688);
      accept_dut(1'b0);
      accept_dut(1'b0);
      accept_dut(1'b0);
      checks++;
      if (total !== 4'd3 || correct !== 4'd3) begin
         failures++;
         $display("FAIL basic_counts: total=%0d correct=%0d required 3 3", total, correct);
      end
      checks++;
      if (mm_pulses !== 0 || busy !== 1'b1 || fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL basic_flags: mm_pulses=%0d busy=%0b count=%0d required 0 1 0",
                  mm_pulses, busy, fifo_count);
      end
   endtask

   task automatic test_mismatch();
      start_run();
      push_exp(128'h0123456789abcdef0011223344556677);
      push_exp(128'hfedcba98765432108899aabbccddeeff);
      // Second DUT value is the first golden value with bit 0 flipped
      exp_q[1] = exp_q[0] ^ 128'h1;
      accept_dut(1'b0);
      checks++;
      if (mismatch !== 1'b0 || total !== 4'd1) begin
         failures++;
         $display("FAIL mm_first: mismatch=%0b total=%0d required 0 1", mismatch, total);
      end
      accept_dut(1'b0);
      checks++;
      if (mismatch !== 1'b1) begin
         failures++;
         $display("FAIL mm_pulse: mismatch=%0b required 1", mismatch);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (mismatch !== 1'b0 || mm_pulses !== 1) begin
         failures++;
         $display("FAIL mm_once: mismatch=%0b pulses=%0d required 0 1", mismatch, mm_pulses);
      end
      checks++;
      if (total !== 4'd2 || correct !== 4'd1) begin
         failures++;
         $display("FAIL mm_counts: total=%0d correct=%0d required 2 1", total, correct);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_fifo();
      int k = 0;
      start_run();
      exp_valid = 1'b1;
      exp_data = 128'hf0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (exp_ready) begin
            exp_q.push_back(exp_data);
            k++;
         end
         @(posedge clk);
         #1;
         exp_data = 128'hf0 + 128'(k);
      end
      @(negedge clk);
      checks++;
      if (k !== 4 || exp_ready !== 1'b0 || fifo_count !== 3'd4) begin
         failures++;
         $display("FAIL full_stop: pushes=%0d exp_ready=%0b count=%0d required 4 0 4",
                  k, exp_ready, fifo_count);
      end
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      accept_dut(1'b0);
      accept_dut(1'b0);
      // count is 2: push and pop together
      exp_valid = 1'b1;
      exp_data = 128'hf4;
      dut_valid = 1'b1;
      dut_data = exp_q[0];
      @(negedge clk);
      checks++;
      if (exp_ready !== 1'b1 || dut_ready !== 1'b1) begin
         failures++;
         $display("FAIL simul_ready: exp_ready=%0b dut_ready=%0b required 1 1", exp_ready, dut_ready);
      end
      @(posedge clk);
      #1;
      void'(exp_q.pop_front());
      exp_q.push_back(128'hf4);
      exp_valid = 1'b0;
      dut_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd2) begin
         failures++;
         $display("FAIL simul_count: count=%0d required 2", fifo_count);
      end
      accept_dut(1'b0);
      accept_dut(1'b0);
      checks++;
      if (total !== 4'd5 || correct !== 4'd5 || fifo_count !== 3'd0 || mm_pulses !== 0) begin
         failures++;
         $display("FAIL full_order: total=%0d correct=%0d count=%0d pulses=%0d required 5 5 0 0",
                  total, correct, fifo_count, mm_pulses);
      end
   endtask

   task automatic test_drain();
      start_run();
      push_exp(128'hd0d0);
      push_exp(128'hd1d1);
      work = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (fsm_state !== 2'd2 || exp_ready !== 1'b0 || dut_ready !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL drain_enter: state=%0d exp_ready=%0b dut_ready=%0b busy=%0b required 2 0 1 1",
                  fsm_state, exp_ready, dut_ready, busy);
      end
      @(posedge clk);
      #1;
      accept_dut(1'b0);
      accept_dut(1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (fsm_state !== 2'd0 || busy !== 1'b0 || dut_ready !== 1'b0) begin
         failures++;
         $display("FAIL drain_idle: state=%0d busy=%0b dut_ready=%0b required 0 0 0",
                  fsm_state, busy, dut_ready);
      end
      checks++;
      if (total !== 4'd2 || correct !== 4'd2) begin
         failures++;
         $display("FAIL drain_counts: total=%0d correct=%0d required 2 2", total, correct);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_saturation_reset();
      start_run();
      for (int i = 0; i < 20; i++) begin
         push_exp(128'h1000 + 128'(i));
         accept_dut(1'b0);
         if (i == 9) begin
            checks++;
            if (total !== 4'd10 || correct !== 4'd10) begin
               failures++;
               $display("FAIL sat_mid: total=%0d correct=%0d required 10 10", total, correct);
            end
         end
      end
      checks++;
      if (total !== 4'd15 || correct !== 4'd15) begin
         failures++;
         $display("FAIL sat_hold: total=%0d correct=%0d required 15 15", total, correct);
      end
      push_exp(128'h2222);
      accept_dut(1'b1);
      checks++;
      if (mismatch !== 1'b1 || total !== 4'd15 || correct !== 4'd15) begin
         failures++;
         $display("FAIL sat_mismatch: mismatch=%0b total=%0d correct=%0d required 1 15 15",
                  mismatch, total, correct);
      end
      // Reset in the middle of a stream of accepts
      push_exp(128'h3333);
      push_exp(128'h4444);
      dut_valid = 1'b1;
      dut_data = 128'h3333;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (total !== 4'd0 || correct !== 4'd0 || mismatch !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_counts: total=%0d correct=%0d mismatch=%0b busy=%0b required 0 0 0 0",
                  total, correct, mismatch, busy);
      end
      checks++;
      if (exp_ready !== 1'b0 || dut_ready !== 1'b0 || fifo_count !== 3'd0 || fsm_state !== 2'd0) begin
         failures++;
         $display("FAIL async_ctrl: exp_ready=%0b dut_ready=%0b count=%0d state=%0d required 0 0 0 0",
                  exp_ready, dut_ready, fifo_count, fsm_state);
      end
      exp_q.delete();
      mm_pulses = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (total !== 4'd0 || correct !== 4'd0 || fifo_count !== 3'd0 || mm_pulses !== 0) begin
         failures++;
         $display("FAIL post_reset: total=%0d correct=%0d count=%0d pulses=%0d required 0 0 0 0",
                  total, correct, fifo_count, mm_pulses);
      end
      dut_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_match();
      test_mismatch();
      test_full_fifo();
      test_drain();
      test_saturation_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/verify_result_checker.md
VERIFY_RESULT_CHECKER -- requirements
Module: verify_result_checker

Interface
REQ-001 Parameter DATA_W, default 128: width of the AES block compared.
REQ-002 Parameter CNT_W, default 32: width of the total and correct counters.
REQ-003 Parameter DEPTH, default 4 (power of two, at least 2): depth of the expected-value FIFO.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 work  input  1  level enable from the verify controller; 1 = run, 0 = stop and drain.
REQ-007 exp_valid  input  1  expected (golden) ciphertext available.
REQ-008 exp_data  input  DATA_W  expected ciphertext.
REQ-009 exp_ready  output  1  checker accepts exp_data this cycle.
REQ-010 dut_valid  input  1  AES core result available.
REQ-011 dut_data  input  DATA_W  AES core ciphertext.
REQ-012 dut_ready  output  1  checker accepts dut_data this cycle.
REQ-013 total  output  CNT_W  number of results compared.
REQ-014 correct  output  CNT_W  number of results equal to expected.
REQ-015 mismatch  output  1  one-cycle pulse per failed compare.
REQ-016 busy  output  1  high in RUN or DRAIN.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-018 IDLE -> RUN when work=1.
REQ-019 RUN -> DRAIN when work=0.
REQ-020 DRAIN -> RUN when work=1.
REQ-021 DRAIN -> IDLE when work=0 and the FIFO is empty.
REQ-022 IDLE: exp_ready=0, dut_ready=0.
REQ-023 exp_ready SHALL equal (state==RUN) and FIFO not full, decoded from registered state and FIFO count; no combinational path from any valid input.
REQ-024 dut_ready SHALL equal (state==RUN or DRAIN) and FIFO not empty.
REQ-025 An expected push occurs on exp_valid and exp_ready; a DUT accept occurs on dut_valid and dut_ready; a transfer occurs only when both valid and ready are 1.
REQ-026 A DUT accept SHALL pop the FIFO head and compare it with dut_data over the full DATA_W.
REQ-027 Push and pop in the same cycle SHALL leave the count unchanged, with FIFO order preserved.
REQ-028 There SHALL be no bypass: a value pushed in cycle N is poppable no earlier than cycle N+1.
REQ-029 Compare result latency is one cycle: after an accept in cycle N, total increments in cycle N+1, correct increments in cycle N+1 if equal, and mismatch=1 for cycle N+1 only if unequal.
REQ-030 Counters SHALL saturate at all-ones.
REQ-031 The compare SHALL still execute at saturation, and mismatch still pulses.
REQ-032 total >= correct SHALL hold at all times.
REQ-033 Counters are cleared only by reset; a work toggle does not clear them.
REQ-034 FIFO pointers are log2(DEPTH) bits with natural wrap-around.
REQ-035 Full/empty SHALL be derived from a separate count register, 0..DEPTH.
REQ-036 busy SHALL equal (state != IDLE), registered.

Reset
REQ-037 While rst_n=0, the FSM SHALL be IDLE.
REQ-038 While rst_n=0, FIFO count and pointers SHALL be 0.
REQ-039 While rst_n=0, total=0, correct=0, mismatch=0, exp_ready=0, dut_ready=0 and busy=0.
REQ-040 Reset asserted mid-operation SHALL discard FIFO contents and any pending compare result, with no counter increment after rst_n rises.
REQ-041 FIFO data storage needs no reset; only pointers and count are reset.

Verification
REQ-042 Basic match: rst_n high at 1003 ns, work=1 at 6006 ns, push 3 expected values, then return 3 identical DUT values -> total=3, correct=3, mismatch never high, busy=1.
REQ-043 Mismatch: push A and B, then DUT returns A, then A^1 -> total=2, correct=1, exactly one mismatch pulse, one cycle after the second accept.
REQ-044 Full FIFO: with DEPTH=4 and dut_valid=0, hold exp_valid=1 -> exp_ready drops after exactly 4 pushes; with push and pop in the same cycle when count is 2, count stays at 2.
REQ-045 Drain: 2 entries queued, work falls -> exp_ready=0 immediately, dut_ready stays 1, after 2 DUT accepts FSM reaches IDLE, busy=0, total=2.
REQ-046 Saturation and reset: force counters near all-ones (CNT_W=4 build), run 20 matching compares -> total=correct=15; assert rst_n=0 mid-stream -> all outputs 0 asynchronously, with no increment after release.
